sym_checker: RTL
================

Name: sym_checker

Overview:
- Consumer end of the symbol generator stream: takes the generated/special/generatedSym outputs plus the player's button and scores the game.
- Decodes each 7-segment symbol back to a digit.
- Opens a response window after every special symbol. Classifies player presses as hits or false presses, and unanswered windows as misses.
- Sits between the symbol generator and the score display/top-level game controller.

Parameters:
- RESP_WINDOW, 50000000, window length in Clk100M cycles after a special symbol (bench uses 8); minimum 2.
- CNT_W, 8, width of the hit/miss/false counters.

Ports:
- Clk100M  input  1  system clock, all logic on rising edge.
- Rst_n  input  1  asynchronous active-low reset.
- genSym  input  1  game period active.
- generated  input  1  one-cycle pulse, new symbol valid on generatedSym.
- special  input  1  qualifies generated: symbol is the target one.
- generatedSym  input  8  active-low segments {dp,g,f,e,d,c,b,a}.
- btnPress  input  1  debounced single-cycle press pulse.
- digit  output  4  last decoded digit, 4'hF if the code is invalid.
- digitValid  output  1  one-cycle pulse, digit updated.
- symErr  output  1  sticky, invalid segment code seen this game.
- windowOpen  output  1  response window active.
- hitCount  output  CNT_W  presses answering a special.
- missCount  output  CNT_W  specials with no press.
- falseCount  output  CNT_W  presses with no open window.

Behaviour:
- Reset values (Rst_n low, asynchronous):
  - digit = 4'hF.
  - digitValid = 0, symErr = 0, windowOpen = 0.
  - All counters = 0.
  - FSM = IDLE, window counter = 0.
- Decode table (hex code -> digit): C0->0, F9->1, A4->2, B0->3, 99->4, 92->5, 82->6, F8->7, 80->8, 90->9.
  - The dp bit is ignored; compare bits [6:0] only.
  - Any other code -> digit = F and symErr is set.
- Decode latency: generated high in cycle N -> digit registered and digitValid high in cycle N+1.
- Decoding and digitValid operate only while genSym = 1.
- FSM states:
  - IDLE: genSym = 0; counters hold; inputs ignored.
  - ARMED: game on, no window open.
  - WINDOW: window open; windowOpen = 1.
- Transitions:
  - IDLE -> ARMED on genSym = 1. On that same edge, all counters and symErr clear.
  - ARMED, generated & special -> WINDOW. The window counter loads RESP_WINDOW-1, so windowOpen is high for exactly RESP_WINDOW cycles starting at N+1.
  - ARMED, btnPress -> falseCount+1.
  - WINDOW, btnPress -> hitCount+1 and return to ARMED. Only one hit per window.
  - WINDOW, counter reaches 0 with no press -> missCount+1 and return to ARMED.
  - Any state, genSym = 0 -> IDLE. An open window is abandoned and not counted as a miss; counters hold their values for display.
- Simultaneous events:
  - btnPress in the same cycle as special while ARMED: counts as a hit for the new special. No window opens.
  - New special while in WINDOW with no press: missCount+1 for the old window, then the window restarts at RESP_WINDOW-1.
  - New special while in WINDOW with a press in the same cycle: hit for the old window, then a fresh window opens.
  - btnPress on the final window cycle: hit, not a miss.
  - special with generated low: ignored.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Reset mid-window: immediate return to reset values; no count is recorded.

Test Plan:
- Reset and decode: Rst_n low then high, genSym = 1. Drive generated with codes C0, F9, 90 in separate cycles -> digitValid pulses one cycle later with digit 0, 1, 9; symErr stays 0.
- Invalid code: generated with code 0xFF -> digit = F, symErr = 1. symErr stays 1 through later valid codes, and clears only when a new game starts.
- Hit, RESP_WINDOW = 8: special in cycle 10 -> windowOpen high cycles 11-18. btnPress in cycle 15 -> hitCount = 1, windowOpen low from cycle 16. A second press in cycle 17 -> falseCount = 1.
- Miss and restart: special with no press -> missCount = 1 after 8 window cycles. Then special at window cycle 4 with no press -> missCount = 2 and the window restarts for another 8 cycles.
- Boundaries:
  - Press coinciding with special -> hitCount+1, windowOpen stays 0.
  - Press on the last window cycle -> hit, missCount unchanged.
  - genSym dropped mid-window -> no miss counted, counters hold.
- Saturation and async reset: CNT_W = 2, 5 false presses -> falseCount = 3. Asserting Rst_n between clock edges clears all outputs immediately.

Source files
------------

// File: rtl/sym_if.sv
// Symbol stream and score bus between the symbol generator,
// the checker and the score display.
interface sym_if #(
  parameter int CNT_W = 8
);
  logic             genSym;
  logic             generated;
  logic             special;
  logic [7:0]       generatedSym;
  logic             btnPress;
  logic [3:0]       digit;
  logic             digitValid;
  logic             symErr;
  logic             windowOpen;
  logic [CNT_W-1:0] hitCount;
  logic [CNT_W-1:0] missCount;
  logic [CNT_W-1:0] falseCount;

  modport master (
    output genSym, generated, special,
    output generatedSym, btnPress,
    input  digit, digitValid, symErr,
    input  windowOpen,
    input  hitCount, missCount, falseCount
  );

  modport slave (
    input  genSym, generated, special,
    input  generatedSym, btnPress,
    output digit, digitValid, symErr,
    output windowOpen,
    output hitCount, missCount, falseCount
  );
endinterface

// File: rtl/sym_checker.sv
// Decodes generated 7-segment symbols and scores player presses
// against response windows opened by special symbols.
module sym_checker #(
  parameter int RESP_WINDOW = 50000000,
  parameter int CNT_W       = 8
) (
  input logic Clk100M,
  input logic Rst_n,
  sym_if.slave bus
);

  localparam int WIN_W = $clog2(RESP_WINDOW);
  localparam logic [WIN_W-1:0] WIN_LOAD =
    WIN_W'(RESP_WINDOW - 1);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    WINDOW
  } state_t;

  state_t           state, state_nxt;
  logic [WIN_W-1:0] wcnt, wcnt_nxt;
  logic             hit_inc, miss_inc, false_inc;
  logic             clr;
  logic             trig;
  logic             dec_en;
  logic [3:0]       dec_digit;
  logic             dec_ok;

  logic [3:0]       digit_q;
  logic             dv_q;
  logic             err_q;
  logic [CNT_W-1:0] hit_q, miss_q, false_q;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

  assign trig   = bus.generated & bus.special;
  assign dec_en = bus.genSym & bus.generated;

  // Segment code to digit, dp bit is don't-care
  always_comb begin
    dec_digit = 4'hF;
    dec_ok    = 1'b1;
    unique casez (bus.generatedSym)
      8'b?100_0000: dec_digit = 4'd0;
      8'b?111_1001: dec_digit = 4'd1;
      8'b?010_0100: dec_digit = 4'd2;
      8'b?011_0000: dec_digit = 4'd3;
      8'b?001_1001: dec_digit = 4'd4;
      8'b?001_0010: dec_digit = 4'd5;
      8'b?000_0010: dec_digit = 4'd6;
      8'b?111_1000: dec_digit = 4'd7;
      8'b?000_0000: dec_digit = 4'd8;
      8'b?001_0000: dec_digit = 4'd9;
      default:      dec_ok    = 1'b0;
    endcase
  end

  // Game state and window counter registers
  always_ff @(posedge Clk100M or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  // Next state, window reload and score events
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    hit_inc   = 1'b0;
    miss_inc  = 1'b0;
    false_inc = 1'b0;
    clr       = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.genSym) begin
          state_nxt = ARMED;
          clr       = 1'b1;
        end
      end
      ARMED: begin
        if (!bus.genSym) begin
          state_nxt = IDLE;
        end else if (trig && bus.btnPress) begin
          hit_inc = 1'b1;
        end else if (trig) begin
          state_nxt = WINDOW;
          wcnt_nxt  = WIN_LOAD;
        end else if (bus.btnPress) begin
          false_inc = 1'b1;
        end
      end
      WINDOW: begin
        if (!bus.genSym) begin
          state_nxt = IDLE;
          wcnt_nxt  = '0;
        end else if (bus.btnPress) begin
          hit_inc = 1'b1;
          if (trig) begin
            wcnt_nxt = WIN_LOAD;
          end else begin
            state_nxt = ARMED;
            wcnt_nxt  = '0;
          end
        end else if (trig) begin
          miss_inc = 1'b1;
          wcnt_nxt = WIN_LOAD;
        end else if (wcnt == '0) begin
          miss_inc  = 1'b1;
          state_nxt = ARMED;
        end else begin
          wcnt_nxt = wcnt - 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        wcnt_nxt  = '0;
      end
    endcase
  end

  // Saturating score counters, cleared at game start
  always_ff @(posedge Clk100M or negedge Rst_n) begin
    if (!Rst_n) begin
      hit_q   <= '0;
      miss_q  <= '0;
      false_q <= '0;
    end else if (clr) begin
      hit_q   <= '0;
      miss_q  <= '0;
      false_q <= '0;
    end else begin
      if (hit_inc)   hit_q   <= sat_inc(hit_q);
      if (miss_inc)  miss_q  <= sat_inc(miss_q);
      if (false_inc) false_q <= sat_inc(false_q);
    end
  end

  // Registered digit, valid pulse and sticky error
  always_ff @(posedge Clk100M or negedge Rst_n) begin
    if (!Rst_n) begin
      digit_q <= 4'hF;
      dv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      dv_q <= dec_en;
      if (dec_en) digit_q <= dec_digit;
      if (clr) err_q <= 1'b0;
      if (dec_en && !dec_ok) err_q <= 1'b1;
    end
  end

  assign bus.digit      = digit_q;
  assign bus.digitValid = dv_q;
  assign bus.symErr     = err_q;
  assign bus.windowOpen = (state == WINDOW);
  assign bus.hitCount   = hit_q;
  assign bus.missCount  = miss_q;
  assign bus.falseCount = false_q;

endmodule
